// File: rtl/pp_fifo2axis_pkg.sv
// Shared types for the ap_fifo -> AXI4-Stream drain adapter: FSM states,
// skid-buffer entry layout and occupancy encoding.
package pp_fifo2axis_pkg;

    // Pixel width carried in a skid entry; the top's DATA_WIDTH must match it.
    localparam int PIX_WIDTH = 11;
    localparam int OCC_WIDTH = 2;

    localparam logic [OCC_WIDTH-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_WIDTH-1:0] OCC_ONE   = 2'd1;
    localparam logic [OCC_WIDTH-1:0] OCC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 tuser;
        logic                 tlast;
        logic [PIX_WIDTH-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/pp_fifo2axis_skid.sv
// Two-entry registered skid buffer in FIFO order; the head entry drives the
// AXI4-Stream outputs and occupancy is fully registered.
module pp_fifo2axis_skid
    import pp_fifo2axis_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  skid_entry_t          i_push_entry,
    input  logic                 i_pop,
    output logic [OCC_WIDTH-1:0] o_occ,
    output skid_entry_t          o_head
);

    skid_entry_t          r_head;
    skid_entry_t          r_tail;
    logic [OCC_WIDTH-1:0] r_occ;
    logic                 w_pop;
    logic                 w_push;

    assign w_pop  = i_pop && (r_occ != OCC_EMPTY);
    assign w_push = i_push && ((r_occ != OCC_FULL) || w_pop);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= r_occ + OCC_WIDTH'(w_push) - OCC_WIDTH'(w_pop);
        end
    end

    // Head is reset so tdata/tlast/tuser read zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
        end else if (w_pop) begin
            if (r_occ == OCC_FULL) begin
                r_head <= r_tail;
            end else if (w_push) begin
                r_head <= i_push_entry;
            end
        end else if (w_push && (r_occ == OCC_EMPTY)) begin
            r_head <= i_push_entry;
        end
    end

    // NOTE: the tail is storage only ever read behind a valid occupancy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push && ((r_occ == OCC_FULL) || ((r_occ == OCC_ONE) && !w_pop))) begin
            r_tail <= i_push_entry;
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/pp_fifo_to_axis_tx.sv
// Drains an HLS ap_fifo read port into an AXI4-Stream master with SOF/EOL tags.
// Optional stall counter port and logic enabled by `define PP_FIFO2AXIS_PERF_EN.
module pp_fifo_to_axis_tx
    import pp_fifo2axis_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_WIDTH,
    parameter int DIM_WIDTH  = 12
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_cols,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
`ifdef PP_FIFO2AXIS_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    state_t               r_state;
    state_t               w_next_state;
    logic [DIM_WIDTH-1:0] r_cols;
    logic [DIM_WIDTH-1:0] r_rows;
    logic [DIM_WIDTH-1:0] r_col;
    logic [DIM_WIDTH-1:0] r_row;
    logic [OCC_WIDTH-1:0] w_occ;
    skid_entry_t          w_head;
    skid_entry_t          w_entry;
    logic                 w_start_ok;
    logic                 w_dims_ok;
    logic                 w_read;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_final_pop;
    logic                 w_beat;
    logic                 w_drained;
    logic                 w_busy;
    logic                 w_done;

    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_dims_ok   = (cfg_cols != '0) && (cfg_rows != '0);
    assign w_col_last  = (r_col == r_cols - DIM_WIDTH'(1));
    assign w_row_last  = (r_row == r_rows - DIM_WIDTH'(1));
    assign w_final_pop = w_read && w_col_last && w_row_last;
    assign w_beat      = m_axis_tvalid && m_axis_tready;
    // In DRAIN nothing is pushed, so the buffer empties when its last entry leaves.
    assign w_drained   = (w_occ == OCC_EMPTY) || ((w_occ == OCC_ONE) && w_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_read       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next_state = w_dims_ok ? RUN : DONE;
            end
            RUN: begin
                w_busy = 1'b1;
                w_read = fifo_empty_n && (w_occ < OCC_FULL);
                if (w_final_pop) w_next_state = DRAIN;
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (w_drained) w_next_state = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Position counters tag each pixel as it is popped, not as it leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cols <= '0;
            r_rows <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_start_ok) begin
            r_cols <= cfg_cols;
            r_rows <= cfg_rows;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_read) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + DIM_WIDTH'(1);
            end else begin
                r_col <= r_col + DIM_WIDTH'(1);
            end
        end
    end

    assign w_entry = '{tuser: (r_row == '0) && (r_col == '0),
                       tlast: w_col_last,
                       data:  fifo_dout};

    pp_fifo2axis_skid u_skid (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_read),
        .i_push_entry (w_entry),
        .i_pop        (m_axis_tready),
        .o_occ        (w_occ),
        .o_head       (w_head)
    );

    assign busy          = w_busy;
    assign done          = w_done;
    assign fifo_read     = w_read;
    assign m_axis_tvalid = (w_occ != OCC_EMPTY);
    assign m_axis_tdata  = w_head.data;
    assign m_axis_tlast  = w_head.tlast;
    assign m_axis_tuser  = w_head.tuser;

`ifdef PP_FIFO2AXIS_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (w_busy && m_axis_tvalid && !m_axis_tready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pp_fifo_to_axis_tx.sv
// Scoreboard bench for pp_fifo_to_axis_tx: stimulus queues expected beats,
// a negedge monitor pops and compares them and tracks skid occupancy.
`timescale 1ns/1ps
module tb_pp_fifo_to_axis_tx;

    localparam int DW = 11;
    localparam int MW = 12;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          eof;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [MW-1:0] cfg_cols = '0;
    logic [MW-1:0] cfg_rows = '0;
    logic          busy;
    logic          done;
    logic          fifo_empty_n;
    logic [DW-1:0] fifo_dout;
    logic          fifo_read;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
`ifdef PP_FIFO2AXIS_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    pp_fifo_to_axis_tx dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_cols      (cfg_cols),
        .cfg_rows      (cfg_rows),
        .busy          (busy),
        .done          (done),
        .fifo_empty_n  (fifo_empty_n),
        .fifo_dout     (fifo_dout),
        .fifo_read     (fifo_read),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef PP_FIFO2AXIS_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source FIFO model; a pipeline reset flushes whatever was left unread.
    logic [DW-1:0] src_mem [0:255];
    int            src_len = 0;
    int            src_rd  = 0;

    assign fifo_empty_n = (src_rd < src_len);
    assign fifo_dout    = src_mem[src_rd[7:0]];

    always @(posedge clk) begin
        if (reset) src_rd <= src_len;
        else if (fifo_read) src_rd <= src_rd + 1;
    end

    logic toggle_rdy = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_rdy) m_axis_tready = ~m_axis_tready;
        else m_axis_tready = 1'b1;
    end

    // Scoreboard and monitor state.
    beat_t         exp_q[$];
    beat_t         mon_e;
    logic          zero_start  = 1'b0;
    int            occ_m       = 0;
    logic          done_due    = 1'b0;
    logic          eof_hs;
    logic          hs;
    int            done_cnt    = 0;
    int            beats_seen  = 0;
    int            cyc         = 0;
    int            first_cyc   = 0;
    int            last_cyc    = 0;
    logic          prev_stall  = 1'b0;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_tags;
    logic [31:0]   stall_m     = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            occ_m      = 0;
            done_due   = 1'b0;
            prev_stall = 1'b0;
            stall_m    = '0;
        end else begin
            check("done", done, done_due);
            if (done) done_cnt++;
            check("tvalid", m_axis_tvalid, occ_m != 0);
            if (fifo_read) check("read_when_full", occ_m >= 2, 0);
            if (prev_stall) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_tags", {m_axis_tlast, m_axis_tuser}, prev_tags);
            end
            hs     = m_axis_tvalid && m_axis_tready;
            eof_hs = 1'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, mon_e.data);
                    check("tlast", m_axis_tlast, mon_e.last);
                    check("tuser", m_axis_tuser, mon_e.user);
                    eof_hs = mon_e.eof;
                    if (mon_e.user) first_cyc = cyc;
                    if (mon_e.eof) last_cyc = cyc;
                end
                beats_seen++;
            end
            done_due = eof_hs || (start && zero_start);
            if (busy && m_axis_tvalid && !m_axis_tready) stall_m = stall_m + 32'd1;
            if (start && !busy && !done) stall_m = '0;
            occ_m      = occ_m + (fifo_read ? 1 : 0) - (hs ? 1 : 0);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_tags  = {m_axis_tlast, m_axis_tuser};
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add_pixels(input int base, input int n);
        for (int i = 0; i < n; i++) src_mem[(src_len + i) % 256] = DW'(base + i);
        src_len += n;
    endtask

    task automatic push_expected(input int cols, input int rows, input int base);
        beat_t e;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.data = DW'(base + r * cols + c);
                e.user = (r == 0) && (c == 0);
                e.last = (c == cols - 1);
                e.eof  = (r == rows - 1) && (c == cols - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int cols, input int rows);
        cfg_cols   = MW'(cols);
        cfg_rows   = MW'(rows);
        zero_start = (cols == 0) || (rows == 0);
        start      = 1'b1;
        cycle();
        start      = 1'b0;
        zero_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while ((done_cnt == d0) && (k < budget)) begin
            cycle();
            k++;
        end
        check("frame_done_seen", done_cnt != d0, 1);
        check("beats_left", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int b0;
        int k;

        repeat (3) cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tdata", m_axis_tdata, 0);
        cycle();

        // 4x2 frame, data 0..7, sink always ready: back-to-back beats.
        add_pixels(0, 8);
        push_expected(4, 2, 0);
        pulse_start(4, 2);
        wait_done(100);
        check("burst_span", last_cyc - first_cyc, 7);

        // Same frame with tready toggling every cycle.
        toggle_rdy = 1'b1;
        add_pixels(16, 8);
        push_expected(4, 2, 16);
        pulse_start(4, 2);
        wait_done(200);
        toggle_rdy = 1'b0;
`ifdef PP_FIFO2AXIS_PERF_EN
        check("stall_cnt", stall_cnt, stall_m);
`endif
        cycle();

        // 3x1 frame with the source running dry mid-line.
        add_pixels(40, 1);
        push_expected(3, 1, 40);
        b0 = beats_seen;
        pulse_start(3, 1);
        repeat (6) cycle();
        check("gap_beats", beats_seen - b0, 1);
        check("gap_tvalid", m_axis_tvalid, 0);
        add_pixels(41, 2);
        wait_done(100);
        cycle();

        // Zero-column start: immediate done, no reads, never busy.
        add_pixels(60, 4);
        d0 = done_cnt;
        pulse_start(0, 5);
        for (int i = 0; i < 4; i++) begin
            check("zero_fifo_read", fifo_read, 0);
            check("zero_busy", busy, 0);
            cycle();
        end
        check("zero_done_count", done_cnt - d0, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // 4x4 frame aborted by reset after beat 5, then a fresh frame.
        add_pixels(100, 16);
        push_expected(4, 4, 100);
        b0 = beats_seen;
        pulse_start(4, 4);
        k = 0;
        while ((beats_seen - b0 < 6) && (k < 100)) begin
            cycle();
            k++;
        end
        check("abort_reached_beat5", beats_seen - b0 >= 6, 1);
        d0 = done_cnt;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("abort_tvalid", m_axis_tvalid, 0);
        check("abort_busy", busy, 0);
        repeat (5) cycle();
        check("abort_no_done", done_cnt - d0, 0);
        add_pixels(200, 8);
        push_expected(4, 2, 200);
        pulse_start(4, 2);
        wait_done(100);
        cycle();

        // Second start during RUN must be ignored.
        add_pixels(300, 8);
        push_expected(4, 2, 300);
        d0 = done_cnt;
        pulse_start(4, 2);
        repeat (2) cycle();
        pulse_start(2, 1);
        wait_done(100);
        repeat (10) cycle();
        check("restart_single_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
